seq_pattern_detector: RTL
=========================

Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector.
- Captures a DATA_W-bit word, shifts it out MSB first one bit per clock, and flags every occurrence of a programmable PAT_W-bit pattern.
- Overlap or non-overlap matching is selected at run time; reports the position of each match and the total match count per word.
- Successor to the fixed 16-bit / "1101" detector; used wherever a serial word must be scanned for a marker pattern.

Parameters:
DATA_W, 16, width of the loaded word (bits scanned per operation)
PAT_W, 4, pattern length in bits; legal range 2..DATA_W
PATTERN, 4'b1101, pattern to detect, PAT_W bits, MSB is the earliest bit in time
CNT_W, 5, width of match_count

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
load  in  1  start request; accepted only in IDLE
data  in  DATA_W  word captured on an accepted load
overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping; sampled with load
busy  out  1  high in SHIFT and DONE
match  out  1  one-cycle pulse per detected pattern occurrence
match_pos  out  $clog2(DATA_W)  consumption index (0 = MSB) of the last bit of the current match; valid while match=1
done  out  1  one-cycle pulse when the word is fully scanned
match_count  out  CNT_W  matches found in the current or last word, saturating

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy, match, done, match_pos, match_count = 0; shift register, history and fill counter cleared. Reset wins over every other event, including a scan in progress; any partial result is discarded.
- States:
  - IDLE: busy=0.
    - load=1 at an edge: capture data into the shift register and latch overlap.
    - Clear history, the fill counter (valid history bits) and match_count.
    - Bit index = 0; next state SHIFT.
    - load=0: stay in IDLE.
  - SHIFT: each edge consumes the shift-register MSB as bit index k (k = 0..DATA_W-1).
    - history <= {history[PAT_W-2:0], bit}; fill counter saturates at PAT_W.
    - If fill+1 >= PAT_W and {history[PAT_W-2:0], bit} == PATTERN: match=1 and match_pos=k after this edge; match_count increments, holding at 2^CNT_W-1.
    - Non-overlap mode: on a match, fill resets to 0, so the next match needs PAT_W fresh bits.
    - Overlap mode: history and fill are kept.
    - On the edge consuming k = DATA_W-1: next state DONE, done=1 after that edge. A match on the last bit is coincident with done.
  - DONE: exactly one cycle. done=0 and match=0 after the next edge; state returns to IDLE. match_count holds until the next accepted load or reset.
- match is 0 in every cycle without a completing bit.
- Latency: load edge to first bit consumed is 1 edge. Load edge to done pulse is DATA_W edges. Back-to-back loads are possible every DATA_W+2 cycles.
- load while busy (SHIFT or DONE) is ignored; it is not queued. data and overlap are don't-care outside the accepting edge.
- No output depends combinationally on any input.

Optional Feature:
- Macro: SEQ_PATTERN_DETECTOR_COUNT_EN.
- Defined: match_count behaves as above.
- Not defined: the counter register is not built and match_count is tied to 0. match, match_pos and done are unchanged.

Test Plan:
1. Defaults; load data=16'hDB6D, overlap=1 -> match pulses at match_pos 3,6,9,12,15; done after 16 edges; match_count=5; the final match coincides with done.
2. Same data, overlap=0 -> matches at match_pos 3,9,15 only; match_count=3.
3. data=16'h0000, then data=16'hFFFF -> no match pulses; done exactly 16 edges after load; match_count=0; busy high for 17 cycles.
4. load asserted continuously, with data changed mid-scan to 16'h0000 -> scan of the first word unaffected; the new load is accepted only in the IDLE cycle after done.
5. rst=1 at edge 5 of a 16'hDB6D scan -> after that edge busy=0, match=0, match_count=0, state IDLE; a new load then scans normally from index 0.
6. CNT_W=2, 16'hDB6D, overlap=1 -> match_count saturates at 3 while 5 match pulses still occur. With SEQ_PATTERN_DETECTOR_COUNT_EN undefined, match_count stays 0.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - serial MSB-first pattern detector with overlap/non-overlap matching.
// Optional match counter is built only when SEQ_PATTERN_DETECTOR_COUNT_EN is defined.
module seq_pattern_detector #(
   parameter int             DATA_W  = 16,
   parameter int             PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter int             CNT_W   = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load,
   input  logic [DATA_W-1:0]         data,
   input  logic                      overlap,
   output logic                      busy,
   output logic                      match,
   output logic [$clog2(DATA_W)-1:0] match_pos,
   output logic                      done,
   output logic [CNT_W-1:0]          match_count
);

   localparam int IDX_W  = $clog2(DATA_W);
   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state_q, state_n;
   logic [DATA_W-1:0]   sreg_q, sreg_n;
   logic                ovl_q, ovl_n;
   logic [PAT_W-2:0]    hist_q, hist_n;
   logic [FILL_W-1:0]   fill_q, fill_n, fill_sat;
   logic [IDX_W-1:0]    idx_q, idx_n;
   logic                match_q, match_n;
   logic [IDX_W-1:0]    pos_q, pos_n;
   logic                done_q, done_n;
   logic [PAT_W-1:0]    new_hist;
   logic                hit;

   // Window formed by the bit consumed this cycle; hit needs a full window of valid bits.
   assign new_hist = {hist_q, sreg_q[DATA_W-1]};
   assign fill_sat = (int'(fill_q) >= PAT_W) ? fill_q : fill_q + 1'b1;
   assign hit      = (state_q == SHIFT) && (int'(fill_q) + 1 >= PAT_W) && (new_hist == PATTERN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         ovl_q   <= 1'b0;
         hist_q  <= '0;
         fill_q  <= '0;
         idx_q   <= '0;
         match_q <= 1'b0;
         pos_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         sreg_q  <= sreg_n;
         ovl_q   <= ovl_n;
         hist_q  <= hist_n;
         fill_q  <= fill_n;
         idx_q   <= idx_n;
         match_q <= match_n;
         pos_q   <= pos_n;
         done_q  <= done_n;
      end
   end

   always_comb begin
      state_n = state_q;
      sreg_n  = sreg_q;
      ovl_n   = ovl_q;
      hist_n  = hist_q;
      fill_n  = fill_q;
      idx_n   = idx_q;
      match_n = 1'b0;
      pos_n   = pos_q;
      done_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               sreg_n  = data;
               ovl_n   = overlap;
               hist_n  = '0;
               fill_n  = '0;
               idx_n   = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            sreg_n = {sreg_q[DATA_W-2:0], 1'b0};
            hist_n = new_hist[PAT_W-2:0];
            idx_n  = idx_q + 1'b1;
            fill_n = fill_sat;
            if (hit) begin
               match_n = 1'b1;
               pos_n   = idx_q;
               // Non-overlap: history bits stay, but they no longer count toward the next window.
               if (!ovl_q) fill_n = '0;
            end
            if (idx_q == LAST_IDX) begin
               state_n = DONE;
               done_n  = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign match     = match_q;
   assign match_pos = pos_q;
   assign done      = done_q;

`ifdef SEQ_PATTERN_DETECTOR_COUNT_EN
   logic [CNT_W-1:0] count_q, count_n;

   always_comb begin
      count_n = count_q;
      if (state_q == IDLE && load) begin
         count_n = '0;
      end else if (hit && count_q != {CNT_W{1'b1}}) begin
         count_n = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_n;
      end
   end

   assign match_count = count_q;
`else
   assign match_count = '0;
`endif

endmodule
